result_writer: RTL and testbench
================================

Name: result_writer

Overview:
- Downstream consumer of the matrix-vector MAC stage.
- When the MAC array signals completion, the block snapshots all NUM_ROWS accumulated sums into a local buffer. It then writes them one per accepted transfer to a memory-mapped result region through an Avalon-MM-style write master.
- Frees the MAC stage to be cleared and reused while results drain.

Parameters:
- NUM_ROWS, 8, number of sums captured and written per job
- SUM_W, 24, width of each MAC sum
- DATA_W, 32, write-data width; must be >= SUM_W
- ADDR_W, 8, word-address width of the write master
- BASE_ADDR, 0, word address of row 0; row i is written to BASE_ADDR+i

Ports:
- clk, input, 1, system clock; all state updates on its rising edge
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, single-cycle pulse from the MAC stage's done; sums are valid in this cycle
- sum, input, NUM_ROWS x SUM_W (unpacked [0:NUM_ROWS-1]), MAC results
- avm_address, output, ADDR_W, word address of current write
- avm_write, output, 1, write request
- avm_writedata, output, DATA_W, zero-extended sum
- avm_waitrequest, input, 1, slave stall; a transfer completes in a cycle with avm_write=1 and avm_waitrequest=0
- busy, output, 1, high from the cycle after an accepted start until the cycle after done
- done, output, 1, one-cycle pulse after the last write is accepted
- overrun, output, 1, sticky flag: start arrived while not IDLE

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state=IDLE, idx=0, buffer cleared.
  - avm_write=0, avm_address=0, avm_writedata=0.
  - busy=0, done=0, overrun=0.
- State IDLE:
  - outputs idle.
  - If start=1, latch sum[0..NUM_ROWS-1] into the buffer, set idx=0 and go to WRITE.
  - The capture uses the sum value present in the start cycle.
- State WRITE:
  - Output drive: avm_write=1, avm_address=BASE_ADDR+idx, avm_writedata={zeros, buf[idx]}.
  - These outputs are registered and held stable while avm_waitrequest=1.
  - On acceptance (avm_waitrequest=0):
    - if idx==NUM_ROWS-1, go to DONE;
    - otherwise idx++ and the next write follows in the very next cycle, with no bubble.
- State DONE: done=1 for exactly one cycle, avm_write=0, then go to IDLE.
- busy=1 in WRITE and DONE.
- Latency, zero-wait slave:
  - start in cycle 0.
  - Writes in cycles 1..NUM_ROWS.
  - done in cycle NUM_ROWS+1.
  - A new start is accepted in cycle NUM_ROWS+2 or later.
- Width rule: avm_writedata[DATA_W-1:SUM_W] is always 0. The sum is treated as unsigned; no sign extension.
- Address arithmetic: BASE_ADDR+idx wraps modulo 2^ADDR_W. No error is raised on wrap.
- start while in WRITE or DONE:
  - ignored; the buffer and idx are untouched;
  - overrun is set to 1 and stays set until reset.
- start in the same cycle as done (DONE state) counts as an overrun.
- avm_waitrequest=1 indefinitely: the block stalls in WRITE with outputs held. There is no timeout.
- Reset mid-transfer: writes stop immediately (avm_write drops asynchronously) and the block returns to IDLE. The partial job is discarded, with no done pulse.
- avm_waitrequest is ignored whenever avm_write=0.

Decomposition:
- Shared package result_pkg contains:
  - state enum {IDLE, WRITE, DONE} as a 2-bit typedef;
  - default constants NUM_ROWS_DEF=8, SUM_W_DEF=24, DATA_W_DEF=32;
  - the sum-array typedef, shared with the MAC stage.
- No sub-module. The capture buffer, index counter and FSM form a single block. The buffer is a register array, not inferred RAM, because all rows load in parallel.

Test Plan:
- Basic job:
  - stimulus: sum[i]=i+1, start pulse, waitrequest=0;
  - required: writes at addresses 0..7 with data 1..8 in cycles 1..8, done in cycle 9, busy high in cycles 1..9.
- Stalls:
  - stimulus: waitrequest high for 3 cycles on row 0 and 2 cycles on row 5;
  - required: address and data held during each stall, 8 writes total, done in cycle 14.
- Zero extension:
  - stimulus: sum[3]=24'hFFFFFF, sum[4]=24'h800000;
  - required: writedata is 32'h00FFFFFF and 32'h00800000.
- Overrun:
  - stimulus: second start in cycle 4 with different sums;
  - required: the original 8 values are written unchanged, overrun=1 from cycle 5 onward, exactly one done.
- Reset mid-transfer:
  - stimulus: rst_n low in cycle 5 for 2 cycles, then a fresh start;
  - required: avm_write drops immediately, no done, overrun=0, the new job writes from address 0.
- Back-to-back jobs and address wrap:
  - stimulus: start in cycle 10 right after done, with BASE_ADDR=252 and ADDR_W=8;
  - required: the second job is accepted, and its addresses run 252..255 then 0..3.

Source files
------------

// File: rtl/result_pkg.sv
// Shared types and defaults for the MAC result writer and the MAC stage feeding it.
package result_pkg;

    localparam int unsigned NUM_ROWS_DEF = 8;
    localparam int unsigned SUM_W_DEF    = 24;
    localparam int unsigned DATA_W_DEF   = 32;

    // Writer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // One job's worth of MAC sums, as produced by the MAC stage
    typedef logic [SUM_W_DEF-1:0] sum_arr_t [0:NUM_ROWS_DEF-1];

endpackage

// File: rtl/result_writer.sv
// Snapshots all MAC sums on start, then drains them one word per accepted
// transfer through an Avalon-MM-style write master, so the MAC stage can be
// cleared and reused while the results are still being written.
module result_writer
    import result_pkg::*;
#(
    parameter int unsigned        NUM_ROWS  = NUM_ROWS_DEF,
    parameter int unsigned        SUM_W     = SUM_W_DEF,
    parameter int unsigned        DATA_W    = DATA_W_DEF,
    parameter int unsigned        ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SUM_W-1:0]  sum [0:NUM_ROWS-1],
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int unsigned      IDX_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROWS - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_nxt;
    // Register array rather than RAM: every row loads in the same cycle
    logic [SUM_W-1:0] sum_buf_q [0:NUM_ROWS-1];

    // Row that follows the current one once it is accepted
    assign idx_nxt = idx_q + 1'b1;

    // FSM, capture buffer and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            for (int i = 0; i < int'(NUM_ROWS); i++) begin
                sum_buf_q[i] <= '0;
            end
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            done <= 1'b0;
            // A start outside IDLE is dropped but remembered until reset
            if (start && state_q != IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sum_buf_q     <= sum;
                        idx_q         <= '0;
                        state_q       <= WRITE;
                        busy          <= 1'b1;
                        // First write is driven straight from the live sums so it
                        // can go out in the cycle right after start
                        avm_write     <= 1'b1;
                        avm_address   <= BASE_ADDR;
                        avm_writedata <= DATA_W'(sum[0]);
                    end
                end
                WRITE: begin
                    if (!avm_waitrequest) begin
                        if (idx_q == LAST_IDX) begin
                            state_q   <= DONE;
                            avm_write <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx_q         <= idx_nxt;
                            // Wraps modulo 2^ADDR_W by truncation
                            avm_address   <= BASE_ADDR + ADDR_W'(idx_nxt);
                            avm_writedata <= DATA_W'(sum_buf_q[idx_nxt]);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    avm_write <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer: per-cycle vector table plus hand-written
// reset and start-during-done sequences. A second instance with BASE_ADDR=252
// shares all inputs and checks address wrap.
module tb_result_writer;
    import result_pkg::*;

    localparam int unsigned NR = 8;
    localparam int unsigned SW = 24;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          wreq = 1'b0;
    logic [SW-1:0] sum [0:NR-1];

    logic [AW-1:0] avm_address, w_address;
    logic          avm_write, w_write;
    logic [DW-1:0] avm_writedata, w_writedata;
    logic          busy, done, overrun;
    logic          w_busy, w_done, w_overrun;

    result_writer #(
        .NUM_ROWS(NR), .SUM_W(SW), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(8'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sum(sum),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_waitrequest(wreq), .busy(busy), .done(done), .overrun(overrun)
    );

    result_writer #(
        .NUM_ROWS(NR), .SUM_W(SW), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(8'd252)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .sum(sum),
        .avm_address(w_address), .avm_write(w_write), .avm_writedata(w_writedata),
        .avm_waitrequest(wreq), .busy(w_busy), .done(w_done), .overrun(w_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        int            sset;
        logic          wreq;
        logic          exp_wr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic          exp_busy;
        logic          exp_done;
        logic          exp_ovr;
    } vec_t;

    vec_t          tv[$];
    logic [DW-1:0] sets [0:2][0:NR-1];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sum(input int ss);
        for (int r = 0; r < int'(NR); r++) sum[r] = sets[ss][r][SW-1:0];
    endtask

    function automatic void push(input logic st, input int ss, input logic wq, input logic ew,
                                 input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                                 input logic eb, input logic edn, input logic eo);
        vec_t v;
        v.start = st; v.sset = ss; v.wreq = wq; v.exp_wr = ew; v.exp_addr = ea;
        v.exp_data = ed; v.exp_busy = eb; v.exp_done = edn; v.exp_ovr = eo;
        tv.push_back(v);
    endfunction

    // One job starting at its cycle 0; stall counts apply to two chosen rows,
    // and an optional extra start (with sum set ovr_set) lands in cycle ovr_cyc.
    // Waitrequest is held high in the start and done cycles, where it must be ignored.
    function automatic void add_job(input int ss, input int row_a, input int n_a,
                                    input int row_b, input int n_b, input int ovr_cyc,
                                    input int ovr_set, input logic ovr_in);
        logic ovr;
        int   cyc;
        int   n;
        ovr = ovr_in;
        cyc = 1;
        push(1'b1, ss, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, ovr);
        for (int r = 0; r < int'(NR); r++) begin
            n = (r == row_a) ? n_a : ((r == row_b) ? n_b : 0);
            for (int s = 0; s <= n; s++) begin
                push(cyc == ovr_cyc, (cyc == ovr_cyc) ? ovr_set : ss, s < n, 1'b1,
                     AW'(r), sets[ss][r], 1'b1, 1'b0, ovr);
                if (cyc == ovr_cyc) ovr = 1'b1;
                cyc++;
            end
        end
        push(1'b0, ss, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, ovr);
    endfunction

    function automatic void add_idle(input int n, input logic ovr);
        for (int k = 0; k < n; k++) push(1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, ovr);
    endfunction

    initial begin
        int nwr;

        for (int r = 0; r < int'(NR); r++) begin
            sets[0][r] = 32'(r + 1);
            sets[2][r] = 32'h00A5_0000 + 32'(r);
        end
        sets[1][0] = 32'h0011_1111; sets[1][1] = 32'h0022_2222;
        sets[1][2] = 32'h0033_3333; sets[1][3] = 32'h00FF_FFFF;
        sets[1][4] = 32'h0080_0000; sets[1][5] = 32'h005A_5A5A;
        sets[1][6] = 32'h0000_0000; sets[1][7] = 32'h007F_FFFF;
        drive_sum(0);

        // Reset state
        #2;
        chk("rst write", 32'(avm_write), 0);
        chk("rst addr", 32'(avm_address), 0);
        chk("rst data", avm_writedata, 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst overrun", 32'(overrun), 0);
        chk("rst wrap addr", 32'(w_address), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Basic job; back-to-back stalled job with zero-extension rows;
        // then a job hit by a second start in cycle 4
        add_job(0, -1, 0, -1, 0, -1, 0, 1'b0);
        add_job(1, 0, 3, 5, 2, -1, 0, 1'b0);
        add_idle(1, 1'b0);
        add_job(0, -1, 0, -1, 0, 4, 2, 1'b0);
        add_idle(2, 1'b1);

        for (int i = 0; i < tv.size(); i++) begin
            start = tv[i].start;
            wreq  = tv[i].wreq;
            drive_sum(tv[i].sset);
            #1;
            chk($sformatf("v%0d write", i), 32'(avm_write), 32'(tv[i].exp_wr));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tv[i].exp_busy));
            chk($sformatf("v%0d done", i), 32'(done), 32'(tv[i].exp_done));
            chk($sformatf("v%0d overrun", i), 32'(overrun), 32'(tv[i].exp_ovr));
            chk($sformatf("v%0d wrap write", i), 32'(w_write), 32'(tv[i].exp_wr));
            if (tv[i].exp_wr) begin
                chk($sformatf("v%0d addr", i), 32'(avm_address), 32'(tv[i].exp_addr));
                chk($sformatf("v%0d data", i), avm_writedata, tv[i].exp_data);
                chk($sformatf("v%0d wrap addr", i), 32'(w_address),
                    32'(AW'(tv[i].exp_addr + 8'd252)));
            end
            tick();
        end
        start = 1'b0;
        wreq  = 1'b0;

        // Reset mid-transfer in cycle 5
        drive_sum(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre-reset write", 32'(avm_write), 1);
        chk("pre-reset addr", 32'(avm_address), 4);
        rst_n = 1'b0;
        #1;
        chk("async write drop", 32'(avm_write), 0);
        chk("async wrap write drop", 32'(w_write), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset overrun", 32'(overrun), 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("in reset done %0d", k), 32'(done), 0);
            chk($sformatf("in reset write %0d", k), 32'(avm_write), 0);
        end
        rst_n = 1'b1;
        tick();
        chk("post-reset done", 32'(done), 0);

        // Fresh job after reset
        drive_sum(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fresh addr", 32'(avm_address), 0);
        chk("fresh data", avm_writedata, sets[1][0]);
        chk("fresh busy", 32'(busy), 1);
        chk("fresh overrun", 32'(overrun), 0);
        nwr = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            if (avm_write) nwr++;
            tick();
        end
        chk("fresh done seen", 32'(done), 1);
        chk("fresh write count", 32'(nwr), 8);

        // Start in the done cycle is an overrun and must not launch a job
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start-at-done overrun", 32'(overrun), 1);
        chk("start-at-done busy", 32'(busy), 0);
        chk("start-at-done write", 32'(avm_write), 0);
        tick();
        chk("start-at-done no job", 32'(avm_write), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
